// File: rtl/pc_pkg.sv
// Constants and types shared by the program counter and the return-address stack.
package pc_pkg;

    localparam int INSTR_ADDR_SIZE = 6;
    localparam int RET_STACK_DEPTH = 8;

    typedef logic [INSTR_ADDR_SIZE-1:0] instr_addr_t;

endpackage : pc_pkg

// File: rtl/ret_addr_stack.sv
// LIFO of return addresses for the PC: call pushes instr_addr + 1, ret pops, and the
// top entry is read combinationally so the PC loads it at the same edge as ret.
import pc_pkg::*;

module ret_addr_stack #(
    parameter int INSTR_ADDR_SIZE = pc_pkg::INSTR_ADDR_SIZE,
    parameter int DEPTH           = pc_pkg::RET_STACK_DEPTH,
    parameter int CW              = $clog2(DEPTH + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       call,
    input  logic                       ret,
    input  logic [INSTR_ADDR_SIZE-1:0] instr_addr,
    output logic [INSTR_ADDR_SIZE-1:0] ret_addr,
    output logic                       empty,
    output logic                       full,
    output logic                       overflow,
    output logic                       underflow,
    output logic [CW-1:0]              dbg_count
);

    // Handshake: call and ret are single-cycle strobes with no backpressure. Each is
    // consumed at the clk rise where it is high; call wins when both are high, and
    // an illegal push/pop leaves the stack untouched and sets a sticky flag instead.

    localparam int W = INSTR_ADDR_SIZE;

    logic [W-1:0]  entry_q [DEPTH];
    logic [W-1:0]  entry_d [DEPTH];
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          overflow_q;
    logic          overflow_d;
    logic          underflow_q;
    logic          underflow_d;
    logic [W-1:0]  push_val;

    assign empty     = (count_q == '0);
    assign full      = (count_q == CW'(DEPTH));
    assign overflow  = overflow_q;
    assign underflow = underflow_q;
    assign dbg_count = count_q;
    assign push_val  = instr_addr + W'(1);

    // Read mux selects entry[count-1]; an empty stack reads as zero.
    always_comb begin
        ret_addr = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i + 1) == count_q) begin
                ret_addr = entry_q[i];
            end
        end
    end

    always_comb begin
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        for (int i = 0; i < DEPTH; i++) begin
            entry_d[i] = entry_q[i];
        end

        if (call) begin
            if (full) begin
                overflow_d = 1'b1;
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (CW'(i) == count_q) begin
                        entry_d[i] = push_val;
                    end
                end
                count_d = count_q + CW'(1);
            end
        end else if (ret) begin
            if (empty) begin
                underflow_d = 1'b1;
            end else begin
                count_d = count_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= '0;
            end
        end else begin
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= entry_d[i];
            end
        end
    end

endmodule : ret_addr_stack

// File: tb/tb_ret_addr_stack.sv
// Randomised and directed bench for ret_addr_stack, checked against a queue-based
// model of a bounded LIFO with sticky overflow/underflow flags.
module tb_ret_addr_stack;

    localparam int W     = 6;
    localparam int DEPTH = 8;
    localparam int CW    = 4;
    localparam int EXP_W = W + 4 + CW;

    logic          clk;
    logic          rst;
    logic          call;
    logic          ret;
    logic [W-1:0]  instr_addr;
    logic [W-1:0]  ret_addr;
    logic          empty;
    logic          full;
    logic          overflow;
    logic          underflow;
    logic [CW-1:0] dbg_count;

    ret_addr_stack #(
        .INSTR_ADDR_SIZE(W),
        .DEPTH          (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .call      (call),
        .ret       (ret),
        .instr_addr(instr_addr),
        .ret_addr  (ret_addr),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow),
        .underflow (underflow),
        .dbg_count (dbg_count)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [W-1:0]     m_stk[$];
    logic             m_ovf;
    logic             m_unf;
    logic [EXP_W-1:0] exp_q[$];
    int               n_cmp;
    int               n_bad;

    function automatic logic [EXP_W-1:0] snapshot();
        logic [W-1:0] top;
        top = (m_stk.size() > 0) ? m_stk[m_stk.size()-1] : '0;
        return {top, (m_stk.size() == 0), (m_stk.size() == DEPTH), m_ovf, m_unf,
                CW'(m_stk.size())};
    endfunction

    task automatic model_reset();
        m_stk.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    // One cycle: expect the outputs visible while the strobe is presented, then
    // advance the model to what the coming clk rise should produce.
    task automatic step(input logic c, input logic r, input logic [W-1:0] a);
        logic [W-1:0] nxt;
        @(negedge clk);
        exp_q.push_back(snapshot());
        call       = c;
        ret        = r;
        instr_addr = a;
        nxt        = a + W'(1);
        if (c) begin
            if (m_stk.size() == DEPTH) m_ovf = 1'b1;
            else m_stk.push_back(nxt);
        end else if (r) begin
            if (m_stk.size() == 0) m_unf = 1'b1;
            else void'(m_stk.pop_back());
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, W'($urandom_range(0, 63)));
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic [EXP_W-1:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("ret_addr",  int'(ret_addr),  int'(e[EXP_W-1 -: W]));
                check("empty",     int'(empty),     int'(e[CW+3]));
                check("full",      int'(full),      int'(e[CW+2]));
                check("overflow",  int'(overflow),  int'(e[CW+1]));
                check("underflow", int'(underflow), int'(e[CW]));
                check("count",     int'(dbg_count), int'(e[CW-1:0]));
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int pcall;
        n_cmp      = 0;
        n_bad      = 0;
        call       = 1'b0;
        ret        = 1'b0;
        instr_addr = '0;
        rst        = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        // reset state, then single call/return
        idle(1);
        step(1'b1, 1'b0, 6'd5);
        step(1'b0, 1'b1, 6'd0);
        idle(1);

        // nested LIFO
        step(1'b1, 1'b0, 6'd10);
        step(1'b1, 1'b0, 6'd20);
        step(1'b1, 1'b0, 6'd30);
        repeat (3) step(1'b0, 1'b1, 6'd0);
        idle(1);

        // wrap at 63, fill, overflow, drain
        step(1'b1, 1'b0, 6'd63);
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, W'(i));
        step(1'b1, 1'b0, 6'd40);
        idle(1);
        repeat (8) step(1'b0, 1'b1, 6'd0);

        // underflow, then a call keeps the flag
        step(1'b0, 1'b1, 6'd0);
        step(1'b1, 1'b0, 6'd3);
        step(1'b1, 1'b0, 6'd10);
        step(1'b1, 1'b1, 6'd50);
        idle(1);

        // async reset between edges with a call in flight
        @(negedge clk);
        call       = 1'b1;
        instr_addr = 6'd17;
        model_reset();
        exp_q.push_back(snapshot());
        #1 rst = 1'b0;
        @(negedge clk);
        call = 1'b0;
        rst  = 1'b1;
        idle(1);

        // randomised phase, alternating push-heavy and pop-heavy bursts
        for (int i = 0; i < 400; i++) begin
            pcall = ((i / 40) % 2 == 0) ? 65 : 25;
            step(($urandom_range(0, 99) < pcall), ($urandom_range(0, 99) < 50),
                 W'($urandom_range(0, 63)));
        end
        idle(2);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_ret_addr_stack

// File: doc/ret_addr_stack.md
Name: ret_addr_stack

Overview:
- LIFO return-address stack that produces the ret_addr consumed by the program counter.
- On a call it pushes (instr_addr + 1), the address after the call instruction.
- On a return it pops, so the top entry is presented on ret_addr in the same cycle the PC samples it.
- Sits beside the PC in the core; driven by the instruction decoder's call/ret strobes.

Parameters:
- INSTR_ADDR_SIZE, 6, width of instruction addresses; must match the PC.
- DEPTH, 8, number of stack entries; must be ≥ 2.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  reset, asynchronous, active-low (0 = reset).
- call  input  1  push strobe; the decoder asserts it together with the PC jmp for call instructions.
- ret  input  1  pop strobe; the same signal that drives the PC ret input.
- instr_addr  input  INSTR_ADDR_SIZE  current PC value.
- ret_addr  output  INSTR_ADDR_SIZE  top-of-stack return address.
- empty  output  1  stack holds 0 entries.
- full  output  1  stack holds DEPTH entries.
- overflow  output  1  sticky: a call was attempted while full.
- underflow  output  1  sticky: a ret was attempted while empty.

Behaviour:
- Reset (rst = 0, asynchronous assert; release is sampled at the next clk rise):
  - count = 0, all entries = 0, ret_addr = 0.
  - empty = 1, full = 0, overflow = 0, underflow = 0.
- Storage: DEPTH registers plus a count register of width $clog2(DEPTH+1).
- ret_addr:
  - Combinational read of entry[count-1] when count > 0, else 0.
  - Carries no added latency, so the PC loads the correct value at the same edge where ret = 1.
- empty = (count == 0); full = (count == DEPTH); both combinational from count.
- Push (call = 1 at a clk rise, not full):
  - entry[count] <= instr_addr + 1, truncated to INSTR_ADDR_SIZE bits (modulo 2^INSTR_ADDR_SIZE, so 63 -> 0 for N = 6).
  - count <= count + 1.
  - The new top appears on ret_addr in the following cycle.
- Pop (ret = 1 at a clk rise, call = 0, not empty):
  - count <= count - 1.
  - The popped entry's contents are left unchanged (no clearing required).
- call and ret both 1:
  - call wins and ret is ignored, matching the PC's jmp-over-ret priority.
  - Full/overflow rules for push apply.
- Push while full:
  - Stack unchanged (no write, count stays DEPTH); overflow <= 1.
- Pop while empty:
  - Stack unchanged; ret_addr stays 0; underflow <= 1.
- overflow and underflow are sticky; they clear only on reset.
- Idle (call = 0, ret = 0): all state holds.
- Reset asserted mid-sequence: state clears immediately, independent of clk; any in-flight strobe is discarded.
- No internal pipelining; every operation is single-cycle, back-to-back at full rate.

Decomposition:
- Shared package pc_pkg holds:
  - INSTR_ADDR_SIZE default constant (6), shared by the PC and this stack.
  - instr_addr_t typedef, logic [INSTR_ADDR_SIZE-1:0].
  - RET_STACK_DEPTH default constant (8).
- No sub-module: register array, count and flags fit in one module.
- Entry storage stays in flops (no RAM macro) so the read is combinational.

Test Plan:
1. Reset: hold rst = 0 for 2 cycles, release -> ret_addr = 0, empty = 1, full = 0, overflow = 0, underflow = 0.
2. Single call/return:
   - instr_addr = 5, call = 1 for 1 cycle -> next cycle ret_addr = 6, empty = 0.
   - ret = 1 for 1 cycle -> ret_addr = 6 during the ret cycle; afterwards empty = 1, ret_addr = 0.
3. Nested LIFO (DEPTH = 8):
   - Calls at instr_addr 10, 20, 30 -> ret_addr = 31.
   - Pop -> 21; pop -> 11; pop -> empty.
4. Wrap and overflow:
   - Call at instr_addr = 63 -> ret_addr = 0.
   - Seven more calls at instr_addr 0..6 -> full = 1, ret_addr = 7.
   - 9th call at instr_addr = 40 -> ret_addr stays 7, count stays 8, overflow = 1 and stays 1 through subsequent pops.
5. Underflow: from empty, ret = 1 -> ret_addr = 0, count = 0, underflow = 1; a later call at instr_addr = 3 -> ret_addr = 4, underflow still 1.
6. Simultaneous strobes and async reset:
   - With top = 11, call = 1 and ret = 1 at instr_addr = 50 -> count + 1, ret_addr = 51.
   - Drop rst mid-cycle (between edges) -> outputs return to reset values before the next clk rise.
